mi_nios_lcd_bus_ctrl: RTL
=========================

# mi_nios_lcd_bus_ctrl

Parametrised successor to the LCD data PIO: an Avalon-MM slave giving Nios II software a DATA_WIDTH-bit bidirectional LCD data port with direction, bit set and bit clear registers. It adds a hardware write sequencer that drives 8080-style cs_n/rs/wr_n strobes with programmable setup, strobe and hold lengths, so software no longer toggles strobes by hand. It sits between the Avalon interconnect and the LCD panel pins.

## Interface
- DATA_WIDTH, 16: LCD data bus width, 1..32.
- SETUP_DEF, 1: reset value of TIMING.setup (cycles).
- STROBE_DEF, 2: reset value of TIMING.strobe (cycles).
- HOLD_DEF, 1: reset value of TIMING.hold (cycles).
- clk  in  1  system clock; one clock domain; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data, zero-extended.
- bidir_port  inout  DATA_WIDTH  LCD data pins.
- lcd_cs_n  out  1  panel chip select, active low, registered.
- lcd_rs  out  1  register/data select (0 = command, 1 = data), registered.
- lcd_wr_n  out  1  write strobe, active low, registered.

## Operation
- Write = chipselect & ~write_n. Register map, bits above DATA_WIDTH ignored on write and read as 0:
  - 0 DATA: write loads data_out; read returns synchronised pins (data_in).
  - 1 DIR: data_dir; bit = 1 drives that pin from data_out.
  - 2 OUTSET: write does data_out |= writedata; read returns data_out.
  - 3 OUTCLR: write does data_out &= ~writedata; read returns 0.
  - 4 TIMING: [7:0] setup, [15:8] strobe, [23:16] hold; read returns current value.
  - 5 WR_CMD: starts a sequenced write with rs = 0, word = writedata[DATA_WIDTH-1:0].
  - 6 WR_DATA: same as WR_CMD but rs = 1.
  - 7 STATUS: read bit0 busy, bit1 dropped (sticky). Writing 1 to bit1 clears dropped.
- data_in: pins pass through a 2-flop synchroniser.
- Pin drive when idle: bit i = data_dir[i] ? data_out[i] : Z.
- Pin drive when busy: all bits driven with the sequencer word, overriding data_dir. data_out and data_dir are not modified and apply again once idle.
- Sequencer FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  - The start write copies TIMING, rs and word into shadow registers. TIMING writes during a cycle affect only later cycles.
  - SETUP: cs_n = 0, wr_n = 1, lasts setup cycles. setup = 0 skips it.
  - STROBE: cs_n = 0, wr_n = 0, lasts max(strobe, 1) cycles.
  - HOLD: cs_n = 0, wr_n = 1, lasts hold cycles. hold = 0 skips it.
  - IDLE: cs_n = 1, wr_n = 1. lcd_rs holds its last value.
  - busy = (state != IDLE).
- A WR_CMD/WR_DATA write while busy is discarded and sets dropped. The running cycle is unaffected.
- A dropped-set event and a clear in the same cycle: the set wins.
- Reset values: readdata 0, data_out 0, data_dir 0 (all pins Z), TIMING = {HOLD_DEF, STROBE_DEF, SETUP_DEF}, lcd_cs_n 1, lcd_wr_n 1, lcd_rs 0, busy 0, dropped 0, synchroniser 0.
- Reset mid-cycle: the FSM returns to IDLE immediately (asynchronously), strobes go high and pins go Z.

## Timing
- Register writes take effect at the clock edge that accepts them.
- readdata is registered every cycle from the current address: read latency 1.
- A pin change reaches readdata 3 edges later (2 synchroniser edges + 1 readdata edge).
- A start accepted at edge T gives state SETUP at T+1, and strobes/pins change at T+1.
- Total cycle length = setup + max(strobe, 1) + hold clocks. busy falls on the edge after the last HOLD cycle.
- A new start may be accepted in the first cycle in which busy = 0. Back-to-back cycles are separated by at least 1 IDLE clock with cs_n = 1.

## Test plan
- Reset, then read all 8 addresses -> readdata 0 except TIMING = 0x00010201; bidir_port all Z; cs_n = wr_n = 1.
- DIR = 0x00FF, DATA = 0xA5A5, OUTSET 0x0100, OUTCLR 0x0005 -> data_out reads 0xA5A0 at address 2; pins [7:0] = 0xA0, [15:8] = Z; externally driven 0x3C00 on [15:8] reads back 0x3CA0 at address 0 three edges after it is applied.
- TIMING = 0x00020301, WR_DATA 0x1234 at edge T -> cs_n low over T+1..T+6; wr_n low exactly over T+2..T+4; rs = 1; pins = 0x1234 over T+1..T+6; busy clears at T+7.
- TIMING = 0 then WR_CMD 0x00FF -> one-clock cycle: wr_n low for 1 clock, rs = 0, cs_n low for 1 clock.
- WR_CMD while busy -> no extra strobe; STATUS = 0x3 during the cycle; write 0x2 to STATUS after idle -> reads 0x0.
- Assert reset_n during STROBE -> wr_n and cs_n go to 1 and pins go Z without waiting for a clock edge; after release, a new WR_DATA runs normally with default timing.

Source files
------------

// File: rtl/mi_nios_lcd_bus_ctrl.sv
// Avalon-MM LCD data port with direction/set/clear registers and an 8080-style
// write sequencer driving cs_n/rs/wr_n with programmable setup, strobe and hold.
module mi_nios_lcd_bus_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SETUP_DEF  = 1,
  parameter int unsigned STROBE_DEF = 2,
  parameter int unsigned HOLD_DEF   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  inout  wire  [DATA_WIDTH-1:0] bidir_port,
  output logic                  lcd_cs_n,
  output logic                  lcd_rs,
  output logic                  lcd_wr_n
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     setup_q, setup_d, strobe_q, strobe_d, hold_q, hold_d;
  logic [DW-1:0]     word_q, word_d;
  logic              rs_sh_q, rs_sh_d;
  logic              go_q, go_d;
  logic              lcd_rs_q, lcd_rs_d, lcd_cs_n_q, lcd_cs_n_d, lcd_wr_n_q, lcd_wr_n_d;
  logic [DW-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0]     data_out_q, data_out_d, data_dir_q, data_dir_d;
  logic [3*TW-1:0]   timing_q, timing_d;
  logic              dropped_q, dropped_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              wr_en_c, seq_wr_c, busy_c, start_c, active_c;
  logic [DW-1:0]     wdata_c, pin_oe_c, pin_val_c;
  logic              unused_wdata_c;

  assign wr_en_c  = chipselect & ~write_n;
  assign wdata_c  = writedata[DW-1:0];
  assign seq_wr_c = wr_en_c & ((address == 3'd5) | (address == 3'd6));
  // An accepted start counts as busy for the one clock before the FSM leaves IDLE.
  assign active_c = (state_q != IDLE);
  assign busy_c   = go_q | active_c;
  assign start_c  = seq_wr_c & ~busy_c;
  assign unused_wdata_c = ^writedata;

  function automatic logic [TW-1:0] last_idx(input logic [TW-1:0] n);
    return (n == '0) ? '0 : n - TW'(1);
  endfunction

  // Register file, read mux and pin synchroniser.
  always_comb begin
    data_out_d = data_out_q;
    data_dir_d = data_dir_q;
    timing_d   = timing_q;
    dropped_d  = dropped_q;
    sync1_d    = bidir_port;
    sync2_d    = sync1_q;
    readdata_d = '0;
    if (wr_en_c) begin
      case (address)
        3'd0: data_out_d = wdata_c;
        3'd1: data_dir_d = wdata_c;
        3'd2: data_out_d = data_out_q | wdata_c;
        3'd3: data_out_d = data_out_q & ~wdata_c;
        3'd4: timing_d   = writedata[3*TW-1:0];
        3'd7: if (writedata[1]) dropped_d = 1'b0;
        default: ;
      endcase
    end
    if (seq_wr_c && busy_c) dropped_d = 1'b1;
    case (address)
      3'd0: readdata_d = 32'(sync2_q);
      3'd1: readdata_d = 32'(data_dir_q);
      3'd2: readdata_d = 32'(data_out_q);
      3'd4: readdata_d = 32'(timing_q);
      3'd7: readdata_d = {30'd0, dropped_q, busy_c};
      default: readdata_d = '0;
    endcase
  end

  // Write sequencer: shadows captured on start, FSM leaves IDLE one clock later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    setup_d  = setup_q;
    strobe_d = strobe_q;
    hold_d   = hold_q;
    word_d   = word_q;
    rs_sh_d  = rs_sh_q;
    lcd_rs_d = lcd_rs_q;
    go_d     = start_c;
    if (start_c) begin
      setup_d  = timing_q[TW-1:0];
      strobe_d = timing_q[2*TW-1:TW];
      hold_d   = timing_q[3*TW-1:2*TW];
      word_d   = wdata_c;
      rs_sh_d  = (address == 3'd6);
    end
    case (state_q)
      IDLE: begin
        if (go_q) begin
          lcd_rs_d = rs_sh_q;
          if (setup_q != '0) begin
            state_d = SETUP;
            cnt_d   = setup_q - TW'(1);
          end else begin
            state_d = STROBE;
            cnt_d   = last_idx(strobe_q);
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = last_idx(strobe_q);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          if (hold_q != '0) begin
            state_d = HOLD;
            cnt_d   = hold_q - TW'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
    lcd_cs_n_d = (state_d == IDLE);
    lcd_wr_n_d = (state_d != STROBE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      setup_q    <= '0;
      strobe_q   <= '0;
      hold_q     <= '0;
      word_q     <= '0;
      rs_sh_q    <= 1'b0;
      go_q       <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_cs_n_q <= 1'b1;
      lcd_wr_n_q <= 1'b1;
      sync1_q    <= '0;
      sync2_q    <= '0;
      data_out_q <= '0;
      data_dir_q <= '0;
      timing_q   <= {TW'(HOLD_DEF), TW'(STROBE_DEF), TW'(SETUP_DEF)};
      dropped_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      setup_q    <= setup_d;
      strobe_q   <= strobe_d;
      hold_q     <= hold_d;
      word_q     <= word_d;
      rs_sh_q    <= rs_sh_d;
      go_q       <= go_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_cs_n_q <= lcd_cs_n_d;
      lcd_wr_n_q <= lcd_wr_n_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      data_out_q <= data_out_d;
      data_dir_q <= data_dir_d;
      timing_q   <= timing_d;
      dropped_q  <= dropped_d;
      readdata_q <= readdata_d;
    end
  end

  // While a cycle runs the sequencer word owns every pin.
  assign pin_oe_c  = active_c ? {DW{1'b1}} : data_dir_q;
  assign pin_val_c = active_c ? word_q : data_out_q;

  for (genvar i = 0; i < DW; i++) begin : g_pin
    assign bidir_port[i] = pin_oe_c[i] ? pin_val_c[i] : 1'bz;
  end

  assign readdata = readdata_q;
  assign lcd_cs_n = lcd_cs_n_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_wr_n = lcd_wr_n_q;

endmodule
